// File: rtl/ifetch_nlp_if.sv
// Snooped core PC port and outgoing prefetch request port of the next-line prefetcher.
interface ifetch_nlp_if #(
    parameter int LADDR_W = 39
);
    logic               coretoictlb_pc_valid;
    logic               coretoictlb_pc_retry;
    logic [LADDR_W-1:0] coretoictlb_pc_laddr;
    logic               pfetol1tlb_req_valid;
    logic               pfetol1tlb_req_retry;
    logic [LADDR_W-1:0] pfetol1tlb_req_laddr;
    logic               pfetol1tlb_req_l2;

    modport master (
        input  coretoictlb_pc_valid,
        input  coretoictlb_pc_retry,
        input  coretoictlb_pc_laddr,
        output pfetol1tlb_req_valid,
        input  pfetol1tlb_req_retry,
        output pfetol1tlb_req_laddr,
        output pfetol1tlb_req_l2
    );

    modport slave (
        output coretoictlb_pc_valid,
        output coretoictlb_pc_retry,
        output coretoictlb_pc_laddr,
        input  pfetol1tlb_req_valid,
        output pfetol1tlb_req_retry,
        input  pfetol1tlb_req_laddr,
        input  pfetol1tlb_req_l2
    );
endinterface

// File: rtl/ifetch_nlp.sv
// Next-line instruction prefetcher: trains on sequential fetch lines and issues line prefetches.
// Define IFETCH_NLP_PAGE_CROSS_EN to let candidates cross 4 KB page boundaries.
module ifetch_nlp #(
    parameter int LADDR_W   = 39,
    parameter int LINE_BITS = 6,
    parameter int DEPTH     = 2,
    parameter int QDEPTH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    ifetch_nlp_if.master bus,
    output logic [15:0]  pf_drop_cnt
);
    localparam int LW    = LADDR_W - LINE_BITS;
    localparam int PG_SH = 12 - LINE_BITS;
    localparam int QAW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int QN    = 1 << QAW;
    localparam int CW    = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [LW-1:0]   cur_line_r, cur_nx_s;
    logic [LW-1:0]   nxt_line_r, nxt_nx_s;
    logic [1:0]      conf_r, conf_nx_s;
    logic            flush_s;

    logic [LW-1:0]   q_line_r [QN];
    logic            q_l2_r   [QN];
    logic [QAW-1:0]  q_wr_r, q_rd_r;
    logic [CW-1:0]   q_cnt_r;

    logic            out_valid_r, out_l2_r;
    logic [LW-1:0]   out_line_r;

    logic            pc_acc_s, seq_s, same_s, same_page_s, cand_s, cand_l2_s, keep_nxt_s;
    logic [LW-1:0]   pc_line_s, dist_s, rel_s;
    logic            out_acc_s, out_free_s, q_empty_s, q_full_s;
    logic            load_q_s, load_c_s, enq_s, drop_s;

    function automatic logic [QAW-1:0] ptr_inc(input logic [QAW-1:0] p);
        return (p == QAW'(QDEPTH - 1)) ? '0 : p + QAW'(1);
    endfunction

    assign pc_acc_s   = bus.coretoictlb_pc_valid & ~bus.coretoictlb_pc_retry;
    assign pc_line_s  = LW'(bus.coretoictlb_pc_laddr >> LINE_BITS);
    assign same_s     = (pc_line_s == cur_line_r);
    assign seq_s      = (pc_line_s == cur_line_r + LW'(1));
    assign dist_s     = nxt_line_r - cur_line_r;
    assign rel_s      = nxt_line_r - pc_line_s;
    assign keep_nxt_s = (rel_s != '0) && (rel_s <= LW'(DEPTH + 1));
    assign cand_l2_s  = (dist_s != LW'(1));

`ifdef IFETCH_NLP_PAGE_CROSS_EN
    assign same_page_s = 1'b1;
`else
    assign same_page_s = (nxt_line_r[LW-1:PG_SH] == cur_line_r[LW-1:PG_SH]);
`endif

    assign cand_s = (state_r == ST_STREAM) & enable & ~pc_acc_s &
                    (dist_s != '0) & (dist_s <= LW'(DEPTH)) & same_page_s;

    // Training FSM: stream detection, confidence and issue pointer.
    always_comb begin
        state_nx_s = state_r;
        cur_nx_s   = cur_line_r;
        conf_nx_s  = conf_r;
        nxt_nx_s   = nxt_line_r;
        flush_s    = 1'b0;
        if (pc_acc_s) begin
            case (state_r)
                ST_IDLE: begin
                    cur_nx_s   = pc_line_s;
                    conf_nx_s  = 2'd0;
                    state_nx_s = ST_TRAIN;
                end
                ST_TRAIN, ST_STREAM: begin
                    if (same_s) begin
                        cur_nx_s = cur_line_r;
                    end else if (seq_s) begin
                        cur_nx_s  = pc_line_s;
                        conf_nx_s = (conf_r == 2'd3) ? 2'd3 : conf_r + 2'd1;
                        if (state_r == ST_TRAIN) begin
                            if (conf_r == 2'd1) begin
                                state_nx_s = ST_STREAM;
                                nxt_nx_s   = pc_line_s + LW'(1);
                            end else begin
                                state_nx_s = ST_TRAIN;
                            end
                        end else if (keep_nxt_s) begin
                            nxt_nx_s = nxt_line_r;
                        end else begin
                            nxt_nx_s = pc_line_s + LW'(1);
                        end
                    end else begin
                        cur_nx_s   = pc_line_s;
                        conf_nx_s  = 2'd0;
                        state_nx_s = ST_TRAIN;
                        flush_s    = 1'b1;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end else if (cand_s) begin
            nxt_nx_s = nxt_line_r + LW'(1);
        end else begin
            nxt_nx_s = nxt_line_r;
        end
    end

    // Training state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cur_line_r <= '0;
            nxt_line_r <= '0;
            conf_r     <= 2'd0;
        end else begin
            state_r    <= state_nx_s;
            cur_line_r <= cur_nx_s;
            nxt_line_r <= nxt_nx_s;
            conf_r     <= conf_nx_s;
        end
    end

    // An empty queue lets a candidate go straight to the output register (2-cycle latency).
    assign out_acc_s  = out_valid_r & ~bus.pfetol1tlb_req_retry;
    assign out_free_s = ~out_valid_r | out_acc_s;
    assign q_empty_s  = (q_cnt_r == '0);
    assign q_full_s   = (q_cnt_r == CW'(QDEPTH));
    assign load_q_s   = out_free_s & ~q_empty_s & ~flush_s;
    assign load_c_s   = out_free_s & q_empty_s & cand_s & ~flush_s;
    assign enq_s      = cand_s & ~flush_s & ~load_c_s & (~q_full_s | load_q_s);
    assign drop_s     = cand_s & ~flush_s & ~load_c_s & q_full_s & ~load_q_s;

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wr_r  <= '0;
            q_rd_r  <= '0;
            q_cnt_r <= '0;
        end else if (flush_s) begin
            q_wr_r  <= '0;
            q_rd_r  <= '0;
            q_cnt_r <= '0;
        end else begin
            if (enq_s) q_wr_r <= ptr_inc(q_wr_r);
            if (load_q_s) q_rd_r <= ptr_inc(q_rd_r);
            case ({enq_s, load_q_s})
                2'b10:   q_cnt_r <= q_cnt_r + CW'(1);
                2'b01:   q_cnt_r <= q_cnt_r - CW'(1);
                default: q_cnt_r <= q_cnt_r;
            endcase
        end
    end

    // Queue storage.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            q_line_r[q_wr_r] <= nxt_line_r;
            q_l2_r[q_wr_r]   <= cand_l2_s;
        end
    end

    // Output register: holds while retried, never withdrawn by a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_line_r  <= '0;
            out_l2_r    <= 1'b0;
        end else if (load_q_s) begin
            out_valid_r <= 1'b1;
            out_line_r  <= q_line_r[q_rd_r];
            out_l2_r    <= q_l2_r[q_rd_r];
        end else if (load_c_s) begin
            out_valid_r <= 1'b1;
            out_line_r  <= nxt_line_r;
            out_l2_r    <= cand_l2_s;
        end else if (out_acc_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_drop_cnt <= 16'd0;
        end else if (drop_s && (pf_drop_cnt != 16'hFFFF)) begin
            pf_drop_cnt <= pf_drop_cnt + 16'd1;
        end
    end

    assign bus.pfetol1tlb_req_valid = out_valid_r;
    assign bus.pfetol1tlb_req_laddr = {out_line_r, {LINE_BITS{1'b0}}};
    assign bus.pfetol1tlb_req_l2    = out_l2_r;
endmodule

// File: doc/ifetch_nlp.md
# ifetch_nlp

Next-line instruction prefetch engine that sits directly upstream of the instruction TLB's prefetch port. It snoops accepted core fetch PCs on the core-to-ictlb PC handshake and detects sequential line streams. Once a stream is confirmed, it issues next-line prefetch requests over the `pfetol1tlb_req` valid/retry interface, with a per-request L1/L2 placement hint.

## Interface
- `LADDR_W`, 39: logical address width.
- `LINE_BITS`, 6: log2 of the cache line size in bytes.
- `DEPTH`, 2: maximum lines prefetched ahead of the current line; range 1..3.
- `QDEPTH`, 4: prefetch queue entries; power of two.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  prefetch enable; when low, no new candidates are generated.
- `coretoictlb_pc_valid`  in  1  core PC request valid (snooped).
- `coretoictlb_pc_retry`  in  1  ictlb retry on the core PC port (snooped).
- `coretoictlb_pc_laddr`  in  LADDR_W  core fetch logical address.
- `pfetol1tlb_req_valid`  out  1  prefetch request valid.
- `pfetol1tlb_req_retry`  in  1  ictlb back-pressure.
- `pfetol1tlb_req_laddr`  out  LADDR_W  line-aligned prefetch address; low LINE_BITS are zero.
- `pfetol1tlb_req_l2`  out  1  placement hint: 0 = fill L1, 1 = fill L2 only.
- `pf_drop_cnt`  out  16  saturating count of candidates dropped because the queue was full.

## Operation
- **Accepted PC.** An accepted PC is a cycle with `coretoictlb_pc_valid & ~coretoictlb_pc_retry`. `line` = `laddr[LADDR_W-1:LINE_BITS]`. Line arithmetic is modulo 2^(LADDR_W-LINE_BITS).
- **State registers.**
  - `cur_line`.
  - `conf`: 2-bit saturating confidence counter.
  - `nxt_line`: issue pointer.
  - FSM with states IDLE / TRAIN / STREAM.
- **IDLE.**
  - Any accepted PC sets `cur_line` = line and `conf` = 0, then goes to TRAIN.
- **TRAIN / STREAM, on an accepted PC:**
  - line == `cur_line`: no change.
  - line == `cur_line`+1 (sequential):
    - `cur_line` = line, `conf`++ (saturates at 3).
    - If `conf` reaches 2 from TRAIN, enter STREAM with `nxt_line` = line+1.
    - Already in STREAM: `nxt_line` = max(`nxt_line`, line+1), compared as distance from `cur_line`.
  - Any other line:
    - `cur_line` = line, `conf` = 0, go to TRAIN.
    - Flush all queued, not-yet-presented entries; the presented head is kept.
- **STREAM candidate generation.** At most one candidate per cycle, generated when all of the following hold:
  - `enable` = 1;
  - `nxt_line` − `cur_line` is in 1..DEPTH;
  - `nxt_line` is in the same 4 KB page as `cur_line`;
  - no accepted PC this cycle.
- **Enqueue.** A candidate is enqueued and `nxt_line`++ is applied.
  - Hint `l2` = 0 when the distance is 1, else 1.
  - Queue full: the candidate is dropped, `pf_drop_cnt` increments (saturating at 0xFFFF), and `nxt_line` still advances.
- **Page limit.** Reaching the page boundary stops generation; the FSM stays in STREAM until the next non-sequential PC.
- **Enable low.** Training continues and the queue drains normally.
- **Output register.** The queue head is loaded into the output register whenever the register is empty or its request is accepted that cycle.
  - Once `valid` = 1, `laddr` and `l2` stay stable until a cycle with `~pfetol1tlb_req_retry`.
  - A flush never withdraws a presented request.

## Timing
- Accepted PC in cycle N: state updates at the end of N.
- The first candidate is generated in N+1 and enqueued at the end of N+1.
- `pfetol1tlb_req_valid` rises in N+2 at the earliest (2-cycle latency).
- Throughput: one request per cycle with retry low.
- Enqueue and dequeue in the same cycle on a full queue are both allowed.
- Flush plus enqueue in the same cycle: the flush wins and the candidate is discarded; no drop count.
- Reset (asynchronous, any time, including mid-stream):
  - FSM = IDLE, queue empty, `conf` = 0.
  - Outputs: `pfetol1tlb_req_valid` = 0, `pfetol1tlb_req_laddr` = 0, `pfetol1tlb_req_l2` = 0, `pf_drop_cnt` = 0.

## Configuration
- `IFETCH_NLP_PAGE_CROSS_EN` defined: the same-page condition is removed and candidates cross 4 KB boundaries, limited only by DEPTH.
- Not defined: generation stops at the boundary of `cur_line`'s page.

## Test plan
- **Stream detect:** accepted PCs 0x1000, 0x1040, 0x1080 on consecutive cycles, retry 0 -> prefetch 0x10C0 with l2=0, then 0x1100 with l2=1; nothing more until the next sequential PC.
- **Back-pressure:** hold `pfetol1tlb_req_retry`=1 for 5 cycles with a request presented -> `laddr`/`l2` unchanged for all 5 cycles; accepted once retry drops; no duplicate request.
- **Redirect flush:** stream active with 2 queued entries, then PC 0x8000 -> head retained, the other queued entries flushed, FSM in TRAIN, `conf`=0.
- **Page boundary:** stream at line 0x1FC0 -> no request for 0x2000 without the macro; 0x2000 issued with `IFETCH_NLP_PAGE_CROSS_EN`.
- **Queue full:** DEPTH=3, QDEPTH=1, retry held high -> `pf_drop_cnt` increments once per dropped candidate.
- **Mid-stream reset:** assert `reset` asynchronously while valid=1 -> valid drops immediately and all outputs are 0; after release, a new stream retrains from IDLE.
